ioctl_rom_loader: RTL and testbench

Buffered bridge from the HPS ioctl download stream to a toggle-handshake memory write port (DDRAM/SDRAM controller). It generalises the cartridge load path to 8- or 16-bit ioctl data, optional byte swap, optional header skip and a configurable-depth write FIFO with back-pressure. It reports the loaded image size and a completion pulse. It sits in the emu top level between `hps_io` and the memory controller.

---
 rtl/ioctl_rom_loader.sv | 266 ++++++++++++++++++++++++++
 tb/tb_ioctl_rom_loader.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ioctl_rom_loader.sv
// ioctl_rom_loader: buffers the HPS ioctl download stream into a small write
// FIFO and drains it through a toggle-handshake memory write port. It can
// drop a leading header, swap the bytes of 16-bit beats, and it reports the
// loaded image size, a completion pulse and a sticky overflow flag.
module ioctl_rom_loader #(
    parameter int DW        = 16,
    parameter int AW        = 25,
    parameter int DEPTH     = 4,
    parameter int HDR_BYTES = 512
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ioctl_download,
    input  logic          ioctl_wr,
    input  logic [AW-1:0] ioctl_addr,
    input  logic [DW-1:0] ioctl_data,
    output logic          ioctl_wait,
    input  logic          hdr_skip,
    input  logic          swap,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic          mem_req,
    input  logic          mem_ack,
    output logic [AW-1:0] rom_size,
    output logic          load_done,
    output logic          overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int NB = DW / 8;

    localparam logic [AW-1:0] HDR_A   = AW'(HDR_BYTES);
    localparam logic [AW-1:0] BEAT_A  = AW'(NB);
    localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
    localparam logic [CW-1:0] HIGH_C  = CW'(DEPTH - 1);

    typedef enum logic {
        S_IDLE,
        S_WAIT_ACK
    } state_t;

    // Download edge detection and per-download latched options
    logic          dl_q;
    logic          skip_q;
    logic          swap_q;
    logic          dl_rise;
    logic          dl_fall;
    logic          skip_eff;
    logic          swap_eff;

    // FIFO storage and bookkeeping
    logic [AW-1:0] fifo_addr [DEPTH];
    logic [DW-1:0] fifo_data [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    // Push path
    logic          in_hdr;
    logic          accept;
    logic          full;
    logic          push;
    logic          drop;
    logic [AW-1:0] push_addr;
    logic [DW-1:0] push_data;
    logic [AW-1:0] push_end;

    // Drain FSM
    state_t        state_q, state_d;
    logic          pop;
    logic          mem_req_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_din_q;

    // Status
    logic [AW-1:0] rom_size_q, rom_size_d;
    logic [AW-1:0] rom_base;
    logic          overflow_q, overflow_d;
    logic          pend_q,     pend_d;
    logic          wait_q,     wait_d;
    logic          load_done_q, load_done_d;
    logic          done_now;

    assign dl_rise  = ioctl_download & ~dl_q;
    assign dl_fall  = ~ioctl_download & dl_q;

    // A beat arriving in the very cycle the download starts already obeys
    // the options being latched in that cycle.
    assign skip_eff = dl_rise ? hdr_skip : skip_q;
    assign swap_eff = dl_rise ? swap     : swap_q;

    assign in_hdr    = skip_eff & (ioctl_addr < HDR_A);
    assign push_addr = ioctl_addr - (skip_eff ? HDR_A : '0);
    assign push_end  = push_addr + BEAT_A;

    // Byte lane reversal; with a single byte lane this is a pass-through.
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_lane
            assign push_data[gi*8 +: 8] = swap_eff ? ioctl_data[(NB-1-gi)*8 +: 8]
                                                   : ioctl_data[gi*8 +: 8];
        end
    endgenerate

    // A download start flushes the FIFO, so a simultaneous beat always fits
    // and nothing is popped from the stale contents.
    assign full   = (count_q == FULL_C);
    assign accept = ioctl_wr & ~in_hdr;
    assign push   = accept & (dl_rise | ~full | pop);
    assign drop   = accept & ~push;

    // Remember the previous download level and the options for this download
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            dl_q   <= 1'b0;
            skip_q <= 1'b0;
            swap_q <= 1'b0;
        end else begin
            dl_q <= ioctl_download;
            if (dl_rise) begin
                skip_q <= hdr_skip;
                swap_q <= swap;
            end
        end
    end

    // FIFO storage write; read side is sampled into the output registers
    always_ff @(posedge clk_sys) begin
        if (push) begin
            fifo_addr[wr_ptr_q] <= push_addr;
            fifo_data[wr_ptr_q] <= push_data;
        end
    end

    // FIFO pointer and occupancy next-state, including flush on download start
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (dl_rise) begin
            rd_ptr_d = wr_ptr_q;
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                count_d  = CW'(1);
            end else begin
                count_d  = '0;
            end
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // FIFO pointer and occupancy registers
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Drain FSM state register
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Drain FSM next state: issue from IDLE, wait for the matching ack
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (pop) state_d = S_WAIT_ACK;
            S_WAIT_ACK: if (mem_ack == mem_req_q) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Drain FSM outputs: pop the head only from IDLE and never during a flush
    always_comb begin
        pop = 1'b0;
        if (state_q == S_IDLE && count_q != '0 && !dl_rise) begin
            pop = 1'b1;
        end
    end

    // Memory request registers; address/data hold until the next issue
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
        end else if (pop) begin
            mem_req_q  <= ~mem_req_q;
            mem_addr_q <= fifo_addr[rd_ptr_q];
            mem_din_q  <= fifo_data[rd_ptr_q];
        end
    end

    // Status next-state: image size, overflow, completion and back-pressure
    always_comb begin
        rom_base   = dl_rise ? '0 : rom_size_q;
        rom_size_d = rom_base;
        if (push && push_end > rom_base) begin
            rom_size_d = push_end;
        end

        overflow_d = dl_rise ? 1'b0 : overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end

        done_now = pend_q & (state_q == S_IDLE) & (count_q == '0) & ~dl_rise;

        pend_d = pend_q;
        if (dl_rise) begin
            pend_d = 1'b0;
        end else if (dl_fall) begin
            pend_d = 1'b1;
        end else if (done_now) begin
            pend_d = 1'b0;
        end

        load_done_d = done_now;
        // One slot stays free for a beat hps_io may already have in flight.
        wait_d = (count_d >= HIGH_C);
    end

    // Status registers
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            rom_size_q  <= '0;
            overflow_q  <= 1'b0;
            pend_q      <= 1'b0;
            load_done_q <= 1'b0;
            wait_q      <= 1'b0;
        end else begin
            rom_size_q  <= rom_size_d;
            overflow_q  <= overflow_d;
            pend_q      <= pend_d;
            load_done_q <= load_done_d;
            wait_q      <= wait_d;
        end
    end

    assign ioctl_wait = wait_q;
    assign mem_addr   = mem_addr_q;
    assign mem_din    = mem_din_q;
    assign mem_req    = mem_req_q;
    assign rom_size   = rom_size_q;
    assign load_done  = load_done_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_ioctl_rom_loader.sv
// Testbench for ioctl_rom_loader: scenario tasks driving the ioctl stream,
// a toggle-handshake memory controller model that logs every write, and a
// reference model of the expected writes and image size.
module tb_ioctl_rom_loader;

    localparam int DW    = 16;
    localparam int AW    = 25;
    localparam int DEPTH = 4;
    localparam int HDR   = 512;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic          clk_sys = 1'b0;
    logic          reset = 1'b1;
    logic          ioctl_download = 1'b0;
    logic          ioctl_wr = 1'b0;
    logic [AW-1:0] ioctl_addr = '0;
    logic [DW-1:0] ioctl_data = '0;
    logic          ioctl_wait;
    logic          hdr_skip = 1'b0;
    logic          swap = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic          mem_req;
    logic          mem_ack = 1'b0;
    logic [AW-1:0] rom_size;
    logic          load_done;
    logic          overflow;

    int  n_checks = 0;
    int  n_fail = 0;

    wr_t obs_q[$];
    wr_t exp_q[$];
    wr_t cur;
    logic last_req = 1'b0;
    bit   pending = 0;
    bit   ack_stall = 0;
    bit   rand_delay = 0;
    bit   unstable = 0;
    int   wait_cnt = 0;
    int   done_cnt = 0;
    time  last_ack_time = 0;
    time  done_time = 0;

    ioctl_rom_loader #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .HDR_BYTES(HDR)) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_data     (ioctl_data),
        .ioctl_wait     (ioctl_wait),
        .hdr_skip       (hdr_skip),
        .swap           (swap),
        .mem_addr       (mem_addr),
        .mem_din        (mem_din),
        .mem_req        (mem_req),
        .mem_ack        (mem_ack),
        .rom_size       (rom_size),
        .load_done      (load_done),
        .overflow       (overflow)
    );

    always #5 clk_sys = ~clk_sys;

    // Memory controller model: logs each request toggle, acks after a delay
    always @(posedge clk_sys) begin
        #1;
        if (reset) begin
            mem_ack  = 1'b0;
            last_req = 1'b0;
            pending  = 0;
        end else begin
            if (pending) begin
                if (mem_addr !== cur.a || mem_din !== cur.d) unstable = 1;
                if (!ack_stall) begin
                    if (wait_cnt == 0) begin
                        mem_ack = mem_req;
                        pending = 0;
                        last_ack_time = $time;
                    end else begin
                        wait_cnt--;
                    end
                end
            end
            if (mem_req !== last_req) begin
                cur.a = mem_addr;
                cur.d = mem_din;
                obs_q.push_back(cur);
                $display("[%0t] write addr=%h data=%h", $time, mem_addr, mem_din);
                last_req = mem_req;
                pending  = 1;
                wait_cnt = rand_delay ? int'($urandom_range(0, 2)) : 0;
                if (!ack_stall && wait_cnt == 0) begin
                    mem_ack = mem_req;
                    pending = 0;
                    last_ack_time = $time;
                end
            end
        end
    end

    // Completion pulse monitor
    always @(posedge clk_sys) begin
        #1;
        if (load_done === 1'b1) begin
            done_cnt++;
            done_time = $time;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected write for one beat, derived from the download options
    function automatic bit model_beat(input bit skip, input bit swp,
                                      input logic [AW-1:0] a, input logic [DW-1:0] d,
                                      output wr_t w);
        int unsigned dv;
        w  = '0;
        dv = int'(d);
        if (skip && int'(a) < HDR) return 0;
        w.a = skip ? AW'(int'(a) - HDR) : a;
        w.d = swp ? DW'(((dv % 256) * 256) + (dv / 256)) : d;
        return 1;
    endfunction

    task automatic tick();
        @(posedge clk_sys);
        #2;
    endtask

    task automatic start_dl(input bit skip, input bit swp);
        hdr_skip = skip;
        swap = swp;
        ioctl_download = 1'b1;
        tick();
        hdr_skip = 1'b0;
        swap = 1'b0;
    endtask

    task automatic end_dl();
        ioctl_download = 1'b0;
        tick();
    endtask

    task automatic beat(input logic [AW-1:0] a, input logic [DW-1:0] d);
        ioctl_wr = 1'b1;
        ioctl_addr = a;
        ioctl_data = d;
        tick();
        ioctl_wr = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (done_cnt > 0) break;
            tick();
        end
        ok = (done_cnt > 0);
        repeat (5) tick();
    endtask

    task automatic clear_logs();
        obs_q.delete();
        exp_q.delete();
        done_cnt = 0;
        unstable = 0;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        reset = 1'b0;
        tick();
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
        n_checks++; if (mem_addr !== '0) begin n_fail++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
        n_checks++; if (mem_din !== '0) begin n_fail++; $display("FAIL reset_mem_din: got %h expected 0", mem_din); end
        n_checks++; if (rom_size !== '0) begin n_fail++; $display("FAIL reset_rom_size: got %h expected 0", rom_size); end
        n_checks++; if (ioctl_wait !== 1'b0) begin n_fail++; $display("FAIL reset_wait: got %b expected 0", ioctl_wait); end
        n_checks++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL reset_load_done: got %b expected 0", load_done); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        $display("test_reset done");
    endtask

    task automatic test_swap();
        bit ok;
        clear_logs();
        exp_q.push_back('{a: 25'd0, d: 16'h3412});
        exp_q.push_back('{a: 25'd2, d: 16'h7856});
        exp_q.push_back('{a: 25'd4, d: 16'hBC9A});
        start_dl(1'b0, 1'b1);
        ioctl_wr = 1'b1; ioctl_addr = 25'd0; ioctl_data = 16'h1234;
        tick();
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL swap_latency_early: mem_req got %b expected 0", mem_req); end
        ioctl_addr = 25'd2; ioctl_data = 16'h5678;
        tick();
        n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL swap_latency_toggle: mem_req got %b expected 1", mem_req); end
        n_checks++; if (mem_din !== 16'h3412) begin n_fail++; $display("FAIL swap_first_din: got %h expected 3412", mem_din); end
        ioctl_addr = 25'd4; ioctl_data = 16'h9ABC;
        tick();
        ioctl_wr = 1'b0;
        end_dl();
        wait_done(100, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL swap_timeout: load_done got none expected one"); end
        n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL swap_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL swap_write%0d: got %h/%h expected %h/%h", i, obs_q[i].a, obs_q[i].d, exp_q[i].a, exp_q[i].d); end
        end
        n_checks++; if (rom_size !== 25'd6) begin n_fail++; $display("FAIL swap_rom_size: got %0d expected 6", rom_size); end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL swap_done_count: got %0d expected 1", done_cnt); end
        n_checks++; if (done_time <= last_ack_time) begin n_fail++; $display("FAIL swap_done_order: done at %0t last ack at %0t", done_time, last_ack_time); end
        n_checks++; if (unstable) begin n_fail++; $display("FAIL swap_stable: addr/data changed before ack"); end
        $display("test_swap done");
    endtask

    task automatic test_hdr_skip();
        bit ok;
        logic [DW-1:0] d0, d1, d2;
        clear_logs();
        d0 = DW'($urandom); d1 = DW'($urandom); d2 = DW'($urandom);
        exp_q.push_back('{a: 25'd0, d: d1});
        exp_q.push_back('{a: 25'd2, d: d2});
        start_dl(1'b1, 1'b0);
        beat(25'd510, d0);
        beat(25'd512, d1);
        beat(25'd514, d2);
        end_dl();
        wait_done(100, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL hdr_timeout: load_done got none expected one"); end
        n_checks++; if (obs_q.size() != 2) begin n_fail++; $display("FAIL hdr_count: got %0d expected 2", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL hdr_write%0d: got %h/%h expected %h/%h", i, obs_q[i].a, obs_q[i].d, exp_q[i].a, exp_q[i].d); end
        end
        n_checks++; if (rom_size !== 25'd4) begin n_fail++; $display("FAIL hdr_rom_size: got %0d expected 4", rom_size); end
        $display("test_hdr_skip done");
    endtask

    task automatic test_backpressure();
        bit ok;
        int pushes;
        wr_t w;
        clear_logs();
        start_dl(1'b0, 1'b0);
        ack_stall = 1;
        w = '{a: 25'd0, d: DW'($urandom)};
        exp_q.push_back(w);
        beat(w.a, w.d);
        tick();
        pushes = 0;
        while (ioctl_wait == 1'b0 && pushes < 10) begin
            w = '{a: AW'(2 + 2 * pushes), d: DW'($urandom)};
            exp_q.push_back(w);
            ioctl_wr = 1'b1; ioctl_addr = w.a; ioctl_data = w.d;
            tick();
            pushes++;
        end
        n_checks++; if (pushes != DEPTH - 1) begin n_fail++; $display("FAIL bp_wait_rise: pushes before wait got %0d expected %0d", pushes, DEPTH - 1); end
        w = '{a: AW'(2 + 2 * pushes), d: DW'($urandom)};
        exp_q.push_back(w);
        ioctl_addr = w.a; ioctl_data = w.d;
        tick();
        ioctl_wr = 1'b0;
        n_checks++; if (ioctl_wait !== 1'b1) begin n_fail++; $display("FAIL bp_wait_held: got %b expected 1", ioctl_wait); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL bp_overflow: got %b expected 0", overflow); end
        repeat (18) tick();
        n_checks++; if (obs_q.size() != 1) begin n_fail++; $display("FAIL bp_stalled: writes got %0d expected 1", obs_q.size()); end
        ack_stall = 0;
        end_dl();
        wait_done(100, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_timeout: load_done got none expected one"); end
        n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL bp_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_write%0d: got %h/%h expected %h/%h", i, obs_q[i].a, obs_q[i].d, exp_q[i].a, exp_q[i].d); end
        end
        n_checks++; if (ioctl_wait !== 1'b0) begin n_fail++; $display("FAIL bp_wait_fall: got %b expected 0", ioctl_wait); end
        n_checks++; if (rom_size !== AW'(2 * DEPTH + 2)) begin n_fail++; $display("FAIL bp_rom_size: got %0d expected %0d", rom_size, 2 * DEPTH + 2); end
        $display("test_backpressure done");
    endtask

    task automatic test_overflow();
        bit ok;
        wr_t w;
        clear_logs();
        start_dl(1'b0, 1'b0);
        ack_stall = 1;
        w = '{a: 25'h100, d: DW'($urandom)};
        exp_q.push_back(w);
        beat(w.a, w.d);
        tick();
        for (int i = 0; i < 6; i++) begin
            w = '{a: AW'(32'h200 + 2 * i), d: DW'($urandom)};
            if (i < DEPTH) exp_q.push_back(w);
            beat(w.a, w.d);
        end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
        n_checks++; if (rom_size !== AW'(32'h200 + 2 * DEPTH)) begin n_fail++; $display("FAIL ovf_rom_size: got %h expected %h", rom_size, 32'h200 + 2 * DEPTH); end
        ack_stall = 0;
        end_dl();
        wait_done(100, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL ovf_timeout: load_done got none expected one"); end
        n_checks++; if (obs_q.size() != DEPTH + 1) begin n_fail++; $display("FAIL ovf_count: got %0d expected %0d", obs_q.size(), DEPTH + 1); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ovf_write%0d: got %h/%h expected %h/%h", i, obs_q[i].a, obs_q[i].d, exp_q[i].a, exp_q[i].d); end
        end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
        $display("test_overflow done");
    endtask

    task automatic test_restart();
        bit ok;
        wr_t w;
        logic [DW-1:0] d;
        clear_logs();
        start_dl(1'b0, 1'b0);
        ack_stall = 1;
        w = '{a: 25'h40, d: DW'($urandom)};
        exp_q.push_back(w);
        beat(w.a, w.d);
        tick();
        beat(25'h42, DW'($urandom));
        end_dl();
        repeat (3) tick();
        start_dl(1'b1, 1'b1);
        n_checks++; if (rom_size !== '0) begin n_fail++; $display("FAIL restart_rom_size: got %h expected 0", rom_size); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL restart_overflow: got %b expected 0", overflow); end
        ack_stall = 0;
        for (int i = 0; i < 2; i++) begin
            d = DW'($urandom);
            if (model_beat(1'b1, 1'b1, AW'(HDR + 2 * i), d, w)) exp_q.push_back(w);
            beat(AW'(HDR + 2 * i), d);
        end
        end_dl();
        wait_done(100, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL restart_timeout: load_done got none expected one"); end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL restart_done_count: got %0d expected 1", done_cnt); end
        n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL restart_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL restart_write%0d: got %h/%h expected %h/%h", i, obs_q[i].a, obs_q[i].d, exp_q[i].a, exp_q[i].d); end
        end
        n_checks++; if (rom_size !== 25'd4) begin n_fail++; $display("FAIL restart_rom_size2: got %0d expected 4", rom_size); end
        $display("test_restart done");
    endtask

    task automatic test_random();
        bit ok, skip, swp;
        int n, guard;
        int exp_size;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        wr_t w;
        rand_delay = 1;
        for (int load = 0; load < 4; load++) begin
            clear_logs();
            skip = 1'($urandom);
            swp  = 1'($urandom);
            exp_size = 0;
            n = int'($urandom_range(5, 20));
            start_dl(skip, swp);
            for (int i = 0; i < n; i++) begin
                repeat ($urandom_range(0, 2)) tick();
                guard = 0;
                while (ioctl_wait == 1'b1 && guard < 50) begin tick(); guard++; end
                a = AW'(2 * $urandom_range(0, 1023));
                d = DW'($urandom);
                if (model_beat(skip, swp, a, d, w)) begin
                    exp_q.push_back(w);
                    if (int'(w.a) + 2 > exp_size) exp_size = int'(w.a) + 2;
                end
                beat(a, d);
            end
            end_dl();
            wait_done(400, ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL rand%0d_timeout: load_done got none expected one", load); end
            n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand%0d_count: got %0d expected %0d", load, obs_q.size(), exp_q.size()); end
            for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
                n_checks++;
                if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand%0d_write%0d: got %h/%h expected %h/%h", load, i, obs_q[i].a, obs_q[i].d, exp_q[i].a, exp_q[i].d); end
            end
            n_checks++; if (rom_size !== AW'(exp_size)) begin n_fail++; $display("FAIL rand%0d_rom_size: got %0d expected %0d", load, rom_size, exp_size); end
            n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rand%0d_overflow: got %b expected 0", load, overflow); end
            n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL rand%0d_done_count: got %0d expected 1", load, done_cnt); end
            n_checks++; if (unstable) begin n_fail++; $display("FAIL rand%0d_stable: addr/data changed before ack", load); end
            $display("test_random load %0d: skip=%0d swap=%0d beats=%0d writes=%0d", load, skip, swp, n, obs_q.size());
        end
        rand_delay = 0;
    endtask

    task automatic test_reset_mid();
        clear_logs();
        start_dl(1'b0, 1'b0);
        ack_stall = 1;
        beat(25'h10, DW'($urandom));
        tick();
        beat(25'h12, DW'($urandom));
        beat(25'h14, DW'($urandom));
        tick();
        reset = 1'b1;
        ioctl_download = 1'b0;
        tick();
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_mem_req: got %b expected 0", mem_req); end
        n_checks++; if (ioctl_wait !== 1'b0) begin n_fail++; $display("FAIL rstmid_wait: got %b expected 0", ioctl_wait); end
        n_checks++; if (rom_size !== '0) begin n_fail++; $display("FAIL rstmid_rom_size: got %h expected 0", rom_size); end
        reset = 1'b0;
        ack_stall = 0;
        repeat (12) tick();
        n_checks++; if (obs_q.size() != 1) begin n_fail++; $display("FAIL rstmid_flushed: writes got %0d expected 1", obs_q.size()); end
        n_checks++; if (done_cnt != 0) begin n_fail++; $display("FAIL rstmid_no_done: pulses got %0d expected 0", done_cnt); end
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_swap();
        test_hdr_skip();
        test_backpressure();
        test_overflow();
        test_restart();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
